// File: rtl/payload_pkg.sv
// Shared definitions for the payload engine group's downstream logic.
//   ENGINE_END_LAT : cycles (with en=1) from an accepted eop until the engine
//                    outputs are final (last state register + End_state register).
//   coll_state_t   : collector emission states.
//   beat_t         : one rule-ID beat {pkt, id, none, last} at default widths.
package payload_pkg;

  localparam int ENGINE_END_LAT = 2;
  localparam int BEAT_PKT_W     = 8;
  localparam int BEAT_ID_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_NONE = 2'd2
  } coll_state_t;

  typedef struct packed {
    logic [BEAT_PKT_W-1:0] pkt;
    logic [BEAT_ID_W-1:0]  id;
    logic                  none;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/payload_lsb_encoder.sv
// Lowest-set-bit priority encoder.
// Ports:
//   vec  (in,  N)    : input vector
//   idx  (out, ID_W) : index of the lowest set bit (0 when vec is zero)
//   any  (out, 1)    : vec has at least one bit set
//   one  (out, 1)    : vec has exactly one bit set
module payload_lsb_encoder #(
  parameter int N    = 64,
  parameter int ID_W = 6
) (
  input  logic [N-1:0]    vec,
  output logic [ID_W-1:0] idx,
  output logic            any,
  output logic            one
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = ID_W'(i);
    end
  end

  assign any = |vec;
  // Clearing the lowest set bit leaves zero only for a one-hot vector.
  assign one = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/payload_match_collector.sv
// Collects the sticky match outputs of a payload engine group. A fixed number
// of enabled cycles after eop the hit vector is snapshotted, then each hit
// engine index is emitted as one beat on a valid/ready stream (lowest index
// first). A zero vector yields a single "none" beat. One snapshot can wait in
// a pending buffer while the active one drains; further snapshots are dropped
// and counted.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   sod, en, eop      : start of data, byte enable, last byte (qualified by en)
//   eng_hit [N_ENG]   : sticky engine outputs
//   m_valid/m_ready   : result stream handshake
//   m_id, m_none,
//   m_last, m_pkt     : beat payload (engine index, no-hit flag, last beat, tag)
//   busy              : active and pending buffers both occupied
//   ovf_cnt [16]      : saturating count of dropped snapshots
//   err_proto         : sticky; eop or sod arrived inside a sample window
module payload_match_collector
  import payload_pkg::*;
#(
  parameter int N_ENG      = 64,
  parameter int ID_W       = 6,
  parameter int SAMPLE_DLY = ENGINE_END_LAT,  // must be >= 1
  parameter int PKT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sod,
  input  logic             en,
  input  logic             eop,
  input  logic [N_ENG-1:0] eng_hit,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ID_W-1:0]  m_id,
  output logic             m_none,
  output logic             m_last,
  output logic [PKT_W-1:0] m_pkt,
  output logic             busy,
  output logic [15:0]      ovf_cnt,
  output logic             err_proto
);

  localparam int CNT_W = $clog2(SAMPLE_DLY + 1);

  logic             eop_acc, snap, accept, act_done, drop;
  logic             win_act, win_zero;
  logic [CNT_W-1:0] win_cnt;
  logic [PKT_W-1:0] pkt_cnt;
  logic [N_ENG-1:0] snap_vec;

  coll_state_t      state, state_nxt;
  logic [N_ENG-1:0] act_vec, act_vec_nxt, pend_vec, pend_vec_nxt;
  logic [PKT_W-1:0] act_pkt, act_pkt_nxt, pend_pkt, pend_pkt_nxt;
  logic             pend_full, pend_full_nxt, act_load, act_keep;
  logic [ID_W-1:0]  enc_idx, m_id_nxt;
  logic             enc_any, enc_one, m_last_nxt;

  assign eop_acc = eop & en;
  // A restarting eop on the final counting edge wins: the old packet is gone.
  assign snap     = win_act & en & (win_cnt == CNT_W'(1)) & ~eop_acc;
  // sod inside the window (including on the snapshot edge) voids the result.
  assign snap_vec = (win_zero | sod) ? '0 : eng_hit;
  assign accept   = m_valid & m_ready;
  assign act_done = accept & m_last;

  // ---- Sample window, tag counter, error and overflow bookkeeping ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_act   <= 1'b0;
      win_cnt   <= '0;
      win_zero  <= 1'b0;
      err_proto <= 1'b0;
      pkt_cnt   <= '0;
      ovf_cnt   <= '0;
    end else begin
      if (eop_acc) begin
        win_act  <= 1'b1;
        win_cnt  <= CNT_W'(SAMPLE_DLY);
        win_zero <= 1'b0;
      end else if (win_act) begin
        if (sod) win_zero <= 1'b1;
        if (en) begin
          win_cnt <= win_cnt - CNT_W'(1);
          if (win_cnt == CNT_W'(1)) win_act <= 1'b0;
        end
      end
      if (win_act & (eop_acc | sod)) err_proto <= 1'b1;
      if (snap) pkt_cnt <= pkt_cnt + PKT_W'(1);
      if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  // ---- Buffer routing: ACTIVE refills from PENDING or a fresh snapshot ----
  always_comb begin : buf_next
    act_vec_nxt   = act_vec;
    act_pkt_nxt   = act_pkt;
    pend_vec_nxt  = pend_vec;
    pend_pkt_nxt  = pend_pkt;
    pend_full_nxt = pend_full;
    act_load      = 1'b0;
    act_keep      = 1'b0;
    drop          = 1'b0;
    if (state == ST_IDLE || act_done) begin
      if (pend_full) begin
        // Promote without a bubble; a same-edge snapshot refills PENDING.
        act_load      = 1'b1;
        act_vec_nxt   = pend_vec;
        act_pkt_nxt   = pend_pkt;
        pend_full_nxt = snap;
        pend_vec_nxt  = snap_vec;
        pend_pkt_nxt  = pkt_cnt;
      end else if (snap) begin
        act_load    = 1'b1;
        act_vec_nxt = snap_vec;
        act_pkt_nxt = pkt_cnt;
      end
    end else begin
      act_keep = 1'b1;
      if (accept) act_vec_nxt = act_vec & (act_vec - N_ENG'(1));
      if (snap) begin
        if (!pend_full) begin
          pend_full_nxt = 1'b1;
          pend_vec_nxt  = snap_vec;
          pend_pkt_nxt  = pkt_cnt;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  // Encodes the vector that will be current after this edge, so m_id/m_last
  // can be registered and still advance one beat per cycle.
  payload_lsb_encoder #(
    .N    (N_ENG),
    .ID_W (ID_W)
  ) u_lsb_enc (
    .vec (act_vec_nxt),
    .idx (enc_idx),
    .any (enc_any),
    .one (enc_one)
  );

  // ---- FSM next state and next beat fields ----
  always_comb begin : fsm_next
    state_nxt = ST_IDLE;
    if (act_load)      state_nxt = enc_any ? ST_EMIT : ST_NONE;
    else if (act_keep) state_nxt = state;
    m_id_nxt   = '0;
    m_last_nxt = 1'b0;
    case (state_nxt)
      ST_EMIT: begin
        m_id_nxt   = enc_idx;
        m_last_nxt = enc_one;
      end
      ST_NONE: m_last_nxt = 1'b1;
      default: ;
    endcase
  end

  // ---- State and control registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pend_full <= 1'b0;
      act_pkt   <= '0;
      m_id      <= '0;
      m_last    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend_full <= pend_full_nxt;
      act_pkt   <= act_pkt_nxt;
      m_id      <= m_id_nxt;
      m_last    <= m_last_nxt;
    end
  end

  // ---- Vector storage (qualified by state/pend_full, no reset needed) ----
  always_ff @(posedge clk) begin
    act_vec  <= act_vec_nxt;
    pend_vec <= pend_vec_nxt;
    pend_pkt <= pend_pkt_nxt;
  end

  // ---- FSM outputs ----
  always_comb begin : fsm_out
    m_valid = (state != ST_IDLE);
    m_none  = (state == ST_NONE);
    busy    = (state != ST_IDLE) & pend_full;
    m_pkt   = act_pkt;
  end

endmodule

// File: doc/payload_match_collector.md
Name: payload_match_collector

Overview:
- Downstream stage of the payload engine array. Consumes the sticky match outputs of all engine_* instances in a payload engine group.
- Snapshots the hit vector at end of payload and serializes the hit engine indices as rule-ID beats on a valid/ready stream toward the alert/header logic.
- Holds one pending snapshot so back-to-back short packets are not lost while the previous result drains.

Parameters:
- N_ENG, 64, number of engine outputs collected (engine index = bit position).
- ID_W, 6, width of the emitted engine index; must satisfy 2**ID_W >= N_ENG.
- SAMPLE_DLY, 2, clk cycles with en=1 between eop acceptance and snapshot. Covers the last state register plus the End_state register.
- PKT_W, 8, width of the packet sequence tag.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: synchronous active-low reset.
- sod, in, 1: start of data; same pulse that clears the engines.
- en, in, 1: byte-enable shared with the engines.
- eop, in, 1: last payload byte; qualified by en.
- eng_hit, in, N_ENG: sticky engine outputs.
- m_valid, out, 1: result beat valid.
- m_ready, in, 1: downstream accept.
- m_id, out, ID_W: hit engine index.
- m_none, out, 1: beat carries no hit (packet had zero matches).
- m_last, out, 1: final beat of this packet.
- m_pkt, out, PKT_W: packet tag, increments per snapshot, wraps.
- busy, out, 1: both active and pending buffers are full.
- ovf_cnt, out, 16: saturating count of dropped snapshots.
- err_proto, out, 1: sticky flag, sod seen inside a sample window.

Behaviour:
- Reset (rst_n=0 at clk edge): m_valid=0, m_id=0, m_none=0, m_last=0, m_pkt=0, busy=0, ovf_cnt=0, err_proto=0. Both buffers empty. Sample counter idle. All other inputs are ignored that cycle. Reset mid-emission discards everything.
- Sample window:
  - eop&en starts a down-counter loaded with SAMPLE_DLY. It decrements only on cycles with en=1.
  - When it reaches 0, eng_hit is captured that same edge (snapshot).
  - eop&en while a window is already running: the window restarts, the earlier packet is discarded, and err_proto is set.
  - sod=1 inside a window: the snapshot is taken as all-zero and err_proto is set.
- Snapshot tag: each snapshot gets tag = pkt counter, and the counter then increments modulo 2**PKT_W.
- Buffers:
  - ACTIVE (being emitted) and PENDING (one deep).
  - A snapshot goes to ACTIVE if it is empty, else to PENDING if that is empty.
  - If both are full, the snapshot is dropped and ovf_cnt increments, saturating at 0xFFFF.
  - busy = ACTIVE full & PENDING full.
  - When ACTIVE empties and PENDING is full, PENDING moves to ACTIVE on the same edge the last beat is accepted. There is no bubble cycle.
- FSM states: IDLE, EMIT, NONE.
  - IDLE -> EMIT: ACTIVE loaded with a nonzero vector.
  - IDLE -> NONE: ACTIVE loaded with a zero vector.
  - EMIT: m_valid=1, m_id = index of the lowest set bit of the working vector, m_none=0. m_last=1 iff exactly one bit remains.
  - EMIT beat accept (m_valid&m_ready): that bit is cleared. After the last accepted beat: if PENDING is full, go to EMIT or NONE per the pending vector; else go to IDLE.
  - NONE: m_valid=1, m_none=1, m_last=1, m_id=0. On accept, same exit rule as EMIT.
- Stream rules:
  - m_id, m_none, m_last and m_pkt are stable while m_valid&!m_ready.
  - m_valid never drops without an accept.
- Latency: first beat is valid 1 clk after the snapshot edge. One beat per cycle under continuous m_ready.
- Lowest-set-bit selection is a combinational priority encoder over N_ENG. m_id is registered.
- Snapshot and accept on the same edge are both honoured: the snapshot lands in PENDING, or in ACTIVE if ACTIVE is emptying with PENDING empty.

Decomposition:
- Shared package payload_pkg holds:
  - the collector state enum (IDLE/EMIT/NONE);
  - the beat struct {pkt, id, none, last};
  - the constant ENGINE_END_LAT = 2, which SAMPLE_DLY defaults to.
- One sub-module: payload_lsb_encoder (N_ENG -> ID_W index plus any/one-hot-remaining flags), reused by other priority users.

Test Plan:
- Single packet, eng_hit=0x...0025 (bits 0,2,5), SAMPLE_DLY=2, m_ready=1 -> beats id=0,2,5. last=1 only on id=5, m_pkt=0, first beat 1 clk after snapshot.
- Zero-hit packet -> one beat with m_none=1, m_last=1, m_id=0, m_pkt increments to 1.
- m_ready held 0 for 5 cycles mid-packet (hits 3,7) -> id=3 held stable, then 3 then 7 delivered, no duplicates.
- Three eops 4 cycles apart with m_ready=0 -> first two queued, third dropped. busy=1, ovf_cnt=1. After m_ready=1, packets tagged 0 and 1 emitted back-to-back with no idle cycle.
- sod pulsed 1 cycle after eop (inside window) -> single m_none beat, err_proto=1 and sticky.
- rst_n=0 during EMIT with PENDING full -> next cycle m_valid=0, busy=0, ovf_cnt=0, m_pkt restarts at 0 on the following packet.
